gpr_arbiter: RTL and testbench

GPR_ARBITER -- requirements
Module: gpr_arbiter

---
 rtl/picomips_pkg.sv | 18 +
 rtl/rr_arb2.sv | 25 ++
 rtl/gpr_arbiter.sv | 135 +++++++++++++
 tb/tb_gpr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared types for the GPR arbiter: controller states, register-number width and count,
// and the per-requester control bundle.
package picomips_pkg;
  localparam int REG_W     = 5;
  localparam int REG_CNT   = 32;
  localparam int NUM_LANES = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
  } req_ctl_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer remembers the last grantee and moves only on a transfer,
// so a requester that keeps its valid high still alternates with the other one.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last;  // index of the most recent grantee

  always_comb begin
    grant = '0;
    if (en) begin
      if (valid[0] && valid[1]) grant = last ? 2'b01 : 2'b10;
      else                      grant = valid;
    end
  end

  // Reset to "req1 went last" so req0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset)       last <= 1'b1;
    else if (|grant) last <= grant[1];
  end
endmodule

// File: rtl/gpr_arbiter.sv
// Two-requester front end for the GPR file: round-robin grant, register-file control muxing and
// latency-1 read responses. Define GPR_ARB_CLEAR_EN to sweep zeros into r1..r31 after reset.
module gpr_arbiter
  import picomips_pkg::*;
#(
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_we,
  input  logic [REG_W-1:0] req0_rd,
  input  logic [REG_W-1:0] req0_rs,
  input  logic [n-1:0]     req0_wdata,
  output logic             rsp0_valid,
  output logic [n-1:0]     rsp0_rd_data,
  output logic [n-1:0]     rsp0_rs_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_we,
  input  logic [REG_W-1:0] req1_rd,
  input  logic [REG_W-1:0] req1_rs,
  input  logic [n-1:0]     req1_wdata,
  output logic             rsp1_valid,
  output logic [n-1:0]     rsp1_rd_data,
  output logic [n-1:0]     rsp1_rs_data,
  output logic             w,
  output logic [n-1:0]     Wdata,
  output logic [REG_W-1:0] Rdno,
  output logic [REG_W-1:0] Rsno,
  input  logic [n-1:0]     Rd,
  input  logic [n-1:0]     Rs
);
  logic [NUM_LANES-1:0]          valid, grant;
  req_ctl_t [NUM_LANES-1:0]      ctl;
  logic [NUM_LANES-1:0][n-1:0]   wdata;
  logic [NUM_LANES-1:0]          rsp_vld;
  logic [NUM_LANES-1:0][n-1:0]   rsp_rd_q, rsp_rs_q;
  logic                          run_en, sweep, sel;
  logic [REG_W-1:0]              sweep_no;

  assign valid = {req1_valid, req0_valid};
  assign ctl   = {req_ctl_t'{req1_we, req1_rd, req1_rs}, req_ctl_t'{req0_we, req0_rd, req0_rs}};
  assign wdata = {req1_wdata, req0_wdata};

`ifdef GPR_ARB_CLEAR_EN
  state_t           state, state_nxt;
  logic [REG_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= REG_W'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Reset gates everything so an aborted cycle never writes or grants.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sweep     = 1'b0;
    run_en    = 1'b0;
    if (state == CLEAR) begin
      sweep   = !reset;
      cnt_nxt = cnt + REG_W'(1);
      if (cnt == REG_W'(REG_CNT - 1)) state_nxt = RUN;
    end else begin
      run_en = !reset;
    end
  end

  assign sweep_no = cnt;
`else
  assign run_en   = !reset;
  assign sweep    = 1'b0;
  assign sweep_no = '0;
`endif

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (run_en),
    .valid (valid),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel        = grant[1];

  always_comb begin
    w     = 1'b0;
    Wdata = '0;
    Rdno  = '0;
    Rsno  = '0;
    if (sweep) begin
      w    = 1'b1;
      Rdno = sweep_no;
    end else if (|grant) begin
      Rdno  = ctl[sel].rd;
      Rsno  = ctl[sel].rs;
      Wdata = wdata[sel];
      w     = ctl[sel].we && (ctl[sel].rd != '0);
    end
  end

  // Rd/Rs are sampled at the same edge that commits any write, so a read of the
  // register being written returns its old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld  <= '0;
      rsp_rd_q <= '0;
      rsp_rs_q <= '0;
    end else begin
      rsp_vld <= grant;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (grant[k]) begin
          rsp_rd_q[k] <= Rd;
          rsp_rs_q[k] <= Rs;
        end
      end
    end
  end

  assign rsp0_valid   = rsp_vld[0];
  assign rsp1_valid   = rsp_vld[1];
  assign rsp0_rd_data = rsp_rd_q[0];
  assign rsp0_rs_data = rsp_rs_q[0];
  assign rsp1_rd_data = rsp_rd_q[1];
  assign rsp1_rs_data = rsp_rs_q[1];
endmodule

// File: tb/tb_gpr_arbiter.sv
// Bench for gpr_arbiter: a GPR file model on the control port, plus a transaction-level
// reference (last-grantee index and a register array) that predicts grants and responses.
module tb_gpr_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_we;
  logic [4:0]   req0_rd, req0_rs;
  logic [N-1:0] req0_wdata;
  logic         rsp0_valid;
  logic [N-1:0] rsp0_rd_data, rsp0_rs_data;
  logic         req1_valid, req1_ready, req1_we;
  logic [4:0]   req1_rd, req1_rs;
  logic [N-1:0] req1_wdata;
  logic         rsp1_valid;
  logic [N-1:0] rsp1_rd_data, rsp1_rs_data;
  logic         w;
  logic [N-1:0] Wdata, Rd, Rs;
  logic [4:0]   Rdno, Rsno;

  always #5 clk = ~clk;

  gpr_arbiter #(.n(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_rd(req0_rd), .req0_rs(req0_rs), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rd_data(rsp0_rd_data), .rsp0_rs_data(rsp0_rs_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_rd(req1_rd), .req1_rs(req1_rs), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rd_data(rsp1_rd_data), .rsp1_rs_data(rsp1_rs_data),
    .w(w), .Wdata(Wdata), .Rdno(Rdno), .Rsno(Rsno), .Rd(Rd), .Rs(Rs)
  );

  // GPR file: combinational read, clocked write, r0 hardwired to zero.
  logic [N-1:0] gpr [32];
  always_comb begin
    Rd = gpr[Rdno];
    Rs = gpr[Rsno];
  end
  always @(posedge clk) if (w && Rdno != 5'd0) gpr[Rdno] <= Wdata;

  // Reference model state.
  logic [N-1:0] mregs [32];
  int           last_g;
  logic [N-1:0] e_rd [2];
  logic [N-1:0] e_rs [2];
  logic [1:0]   e_vld;

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [N-1:0] wd);
    req0_valid = v; req0_we = we; req0_rd = rd; req0_rs = rs; req0_wdata = wd;
  endtask

  task automatic set1(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [N-1:0] wd);
    req1_valid = v; req1_we = we; req1_rd = rd; req1_rs = rs; req1_wdata = wd;
  endtask

  // One bus cycle: predict the grantee from the valids and the last grantee, check the GPR
  // control port mid-cycle, apply the transaction to the model, then check the responses.
  task automatic cycle();
    int           g;
    logic [4:0]   erd, ers;
    logic [N-1:0] ewd;
    logic         ew;
    @(negedge clk);
    if (req0_valid && req1_valid) g = 1 - last_g;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    else                          g = -1;
    erd = '0; ers = '0; ewd = '0; ew = 1'b0;
    if (g == 0) begin erd = req0_rd; ers = req0_rs; ewd = req0_wdata; ew = req0_we; end
    if (g == 1) begin erd = req1_rd; ers = req1_rs; ewd = req1_wdata; ew = req1_we; end
    ew = ew && (erd != 5'd0);
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    chk("w",      32'(w),     32'(ew));
    chk("Rdno",   32'(Rdno),  32'(erd));
    chk("Rsno",   32'(Rsno),  32'(ers));
    chk("Wdata",  32'(Wdata), 32'(ewd));
    e_vld = 2'b00;
    if (g >= 0) begin
      e_rd[g]  = mregs[erd];
      e_rs[g]  = mregs[ers];
      e_vld[g] = 1'b1;
      if (ew) mregs[erd] = ewd;
      last_g = g;
    end
    @(posedge clk); #1;
    chk("rsp0_valid",   32'(rsp0_valid),   32'(e_vld[0]));
    chk("rsp1_valid",   32'(rsp1_valid),   32'(e_vld[1]));
    chk("rsp0_rd_data", 32'(rsp0_rd_data), 32'(e_rd[0]));
    chk("rsp0_rs_data", 32'(rsp0_rs_data), 32'(e_rs[0]));
    chk("rsp1_rd_data", 32'(rsp1_rd_data), 32'(e_rd[1]));
    chk("rsp1_rs_data", 32'(rsp1_rs_data), 32'(e_rs[1]));
  endtask

`ifdef GPR_ARB_CLEAR_EN
  // Zero sweep with both requesters waiting; optionally abort by reset at step abort_at.
  task automatic sweep(input int abort_at);
    set0(1'b1, 1'b1, 5'd3, 5'd4, 8'h55);
    set1(1'b1, 1'b1, 5'd6, 5'd2, 8'h66);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("clr_ready0", 32'(req0_ready), 32'd0);
      chk("clr_ready1", 32'(req1_ready), 32'd0);
      chk("clr_w",      32'(w),          32'd1);
      chk("clr_Rdno",   32'(Rdno),       32'(i));
      chk("clr_Wdata",  32'(Wdata),      32'd0);
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("abort_rsp1_valid", 32'(rsp1_valid), 32'd0);
        return;
      end
      @(posedge clk); #1;
    end
    for (int i = 1; i < 32; i++) mregs[i] = '0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [N-1:0] v;
      v = (i == 0) ? '0 : N'($urandom);
      gpr[i]   = v;
      mregs[i] = v;
    end
    // Requests held high through reset must not be granted or write.
    reset = 1'b1;
    set0(1'b1, 1'b1, 5'd9, 5'd1, 8'h12);
    set1(1'b1, 1'b1, 5'd8, 5'd2, 8'h34);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_w",      32'(w),            32'd0);
    chk("rst_ready0", 32'(req0_ready),   32'd0);
    chk("rst_ready1", 32'(req1_ready),   32'd0);
    chk("rst_rsp0_v", 32'(rsp0_valid),   32'd0);
    chk("rst_rsp1_v", 32'(rsp1_valid),   32'd0);
    chk("rst_rsp0_d", 32'(rsp0_rd_data), 32'd0);
    chk("rst_rsp1_d", 32'(rsp1_rs_data), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    last_g = 1;
    e_vld  = 2'b00;
    for (int k = 0; k < 2; k++) begin e_rd[k] = '0; e_rs[k] = '0; end

`ifdef GPR_ARB_CLEAR_EN
    sweep(10);
    sweep(0);
    cycle();  // first grant after the sweep goes to req0
`endif

    // Write r5 from req0, then read it back from req1 on the next cycle.
    set0(1'b1, 1'b1, 5'd5, 5'd0, 8'h3C);
    set1(1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    cycle();
    set0(1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    set1(1'b1, 1'b0, 5'd3, 5'd5, 8'h00);
    cycle();
    chk("raw_r5", 32'(rsp1_rs_data), 32'h3C);

    // Sustained contention alternates grantees.
    set0(1'b1, 1'b0, 5'd1, 5'd2, 8'h00);
    set1(1'b1, 1'b0, 5'd3, 5'd4, 8'h00);
    repeat (4) cycle();

    // Writes to r0 are dropped and r0 reads as zero.
    set0(1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    set1(1'b1, 1'b1, 5'd0, 5'd0, 8'hFF);
    cycle();
    set1(1'b1, 1'b0, 5'd0, 5'd0, 8'h00);
    cycle();
    chk("r0_zero", 32'(rsp1_rd_data), 32'd0);

    // Same-transaction write/read sees old value; the next read sees the new one.
    set1(1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    set0(1'b1, 1'b1, 5'd7, 5'd0, 8'hAA);
    cycle();
    set0(1'b1, 1'b1, 5'd7, 5'd7, 8'h11);
    cycle();
    chk("wr_rd_old", 32'(rsp0_rs_data), 32'hAA);
    set0(1'b1, 1'b0, 5'd7, 5'd0, 8'h00);
    cycle();
    chk("wr_rd_new", 32'(rsp0_rd_data), 32'h11);

    // Idle cycles: responses must hold.
    set0(1'b0, 1'b0, 5'd0, 5'd0, 8'h00);
    repeat (2) cycle();

    // Randomized traffic on a small register window to provoke hazards.
    for (int t = 0; t < 300; t++) begin
      set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), N'($urandom));
      set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), N'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
